// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/EXECUTE/MEM/WB/TRAP control for a simple core.
// Define CORE_SEQ_TIMEOUT_EN to trap memory accesses that wait too long for mem_ack.
module core_sequencer #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR   = '0,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    input  logic            mem_err,
    output logic [31:0]     instr,
    input  logic            dec_load,
    input  logic            dec_store,
    input  logic            dec_branch,
    input  logic            dec_wb,
    input  logic            dec_illegal,
    input  logic [XLEN-1:0] alu_result,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] rs2_data,
    output logic            rf_we,
    output logic [XLEN-1:0] rf_wdata,
    output logic [XLEN-1:0] pc,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic            retire
);

    typedef enum logic [2:0] {
        FETCH,
        EXECUTE,
        MEM,
        WB,
        TRAP
    } state_e;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [1:0]  C_ILL  = 2'd1;
    localparam logic [1:0]  C_MERR = 2'd2;
    localparam logic [1:0]  C_TMO  = 2'd3;

    if (XLEN < 32 || (XLEN % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("core_sequencer: unsupported parameter values");
    end

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [31:0]     instr_q, instr_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic            rf_we_q, rf_we_d;
    logic            trap_q, trap_d;
    logic            retire_q, retire_d;
    logic [1:0]      cause_q, cause_d;

    logic            trap_now;
    logic [1:0]      trap_code;
    logic            drop;
    logic            tmo;
    logic            wb_we;

    assign wb_we = dec_wb & ~dec_store & ~dec_branch;

`ifdef CORE_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is zero whenever no access is outstanding.
    always_comb begin
        cnt_d = '0;
        if (req_q && !mem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tmo = req_q && !mem_ack &&
                 (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        instr_d    = instr_q;
        req_d      = req_q;
        we_d       = we_q;
        cause_d    = cause_q;
        rf_we_d    = 1'b0;
        rf_wdata_d = '0;
        trap_d     = 1'b0;
        retire_d   = 1'b0;
        trap_now   = 1'b0;
        trap_code  = 2'd0;
        drop       = 1'b0;

        unique case (state_q)
            FETCH: begin
                // First cycle out of reset: start the fetch.
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end else if (tmo) begin
                    trap_now  = 1'b1;
                    trap_code = C_TMO;
                end else if (mem_ack) begin
                    if (mem_err) begin
                        trap_now  = 1'b1;
                        trap_code = C_MERR;
                    end else begin
                        instr_d = mem_rdata[31:0];
                        state_d = EXECUTE;
                        drop    = 1'b1;
                    end
                end
            end
            EXECUTE: begin
                if (dec_illegal) begin
                    trap_now  = 1'b1;
                    trap_code = C_ILL;
                end else if (dec_load || dec_store) begin
                    state_d = MEM;
                    req_d   = 1'b1;
                    addr_d  = alu_result;
                    we_d    = dec_store;
                    wdata_d = rs2_data;
                end else begin
                    state_d    = WB;
                    rf_we_d    = wb_we;
                    rf_wdata_d = alu_result;
                    retire_d   = 1'b1;
                end
            end
            MEM: begin
                if (tmo) begin
                    trap_now  = 1'b1;
                    trap_code = C_TMO;
                end else if (mem_ack) begin
                    if (mem_err) begin
                        trap_now  = 1'b1;
                        trap_code = C_MERR;
                    end else begin
                        state_d    = WB;
                        drop       = 1'b1;
                        rf_we_d    = wb_we;
                        rf_wdata_d = dec_load ? mem_rdata : alu_result;
                        retire_d   = 1'b1;
                    end
                end
            end
            WB: begin
                pc_d    = (dec_branch && branch_taken) ?
                          alu_result : pc_q + XLEN'(4);
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = pc_d;
                we_d    = 1'b0;
                wdata_d = '0;
            end
            TRAP: begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = RESET_VECTOR;
                we_d    = 1'b0;
                wdata_d = '0;
            end
            default: begin
                state_d = FETCH;
                drop    = 1'b1;
            end
        endcase

        if (trap_now) begin
            state_d  = TRAP;
            trap_d   = 1'b1;
            cause_d  = trap_code;
            pc_d     = RESET_VECTOR;
            drop     = 1'b1;
            rf_we_d  = 1'b0;
            retire_d = 1'b0;
        end

        // An idle bus drives zeros on address, strobe and data.
        if (drop) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_VECTOR;
            addr_q     <= '0;
            wdata_q    <= '0;
            instr_q    <= NOP;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            cause_q    <= 2'd0;
            rf_we_q    <= 1'b0;
            rf_wdata_q <= '0;
            trap_q     <= 1'b0;
            retire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            instr_q    <= instr_d;
            req_q      <= req_d;
            we_q       <= we_d;
            cause_q    <= cause_d;
            rf_we_q    <= rf_we_d;
            rf_wdata_q <= rf_wdata_d;
            trap_q     <= trap_d;
            retire_q   <= retire_d;
        end
    end

    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign instr      = instr_q;
    assign rf_we      = rf_we_q;
    assign rf_wdata   = rf_wdata_q;
    assign pc         = pc_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign retire     = retire_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: per-cycle expectations built from instruction plans.
// Honours CORE_SEQ_TIMEOUT_EN the same way as the design.
module tb_core_sequencer;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0;
    localparam int          TMO  = 16;

    logic        clk;
    logic        reset_n;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, mem_err;
    logic [31:0] instr;
    logic        dec_load, dec_store, dec_branch, dec_wb, dec_illegal;
    logic [31:0] alu_result, rs2_data;
    logic        branch_taken;
    logic        rf_we;
    logic [31:0] rf_wdata, pc;
    logic        trap;
    logic [1:0]  trap_cause;
    logic        retire;

    core_sequencer #(
        .XLEN(XLEN),
        .RESET_VECTOR(RV),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .mem_err(mem_err),
        .instr(instr),
        .dec_load(dec_load),
        .dec_store(dec_store),
        .dec_branch(dec_branch),
        .dec_wb(dec_wb),
        .dec_illegal(dec_illegal),
        .alu_result(alu_result),
        .branch_taken(branch_taken),
        .rs2_data(rs2_data),
        .rf_we(rf_we),
        .rf_wdata(rf_wdata),
        .pc(pc),
        .trap(trap),
        .trap_cause(trap_cause),
        .retire(retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ins;
        logic [31:0] pcv;
        bit          rfwe;
        bit          chk_wd;
        logic [31:0] wd;
        bit          trp;
        logic [1:0]  cause;
        bit          ret;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pc_m;
    logic [31:0] instr_m;
    logic [1:0]  cause_m;
    logic [31:0] last_wd = '0;
    logic [31:0] last_st = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (retire) last_wd = rf_wdata;
        if (mem_req && mem_we) last_st = mem_wdata;
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            chk("mem_req", 32'(mem_req), 32'(ce.req));
            chk("mem_we", 32'(mem_we), 32'(ce.we));
            chk("mem_addr", mem_addr, ce.addr);
            chk("mem_wdata", mem_wdata, ce.wdata);
            chk("instr", instr, ce.ins);
            chk("pc", pc, ce.pcv);
            chk("rf_we", 32'(rf_we), 32'(ce.rfwe));
            chk("trap", 32'(trap), 32'(ce.trp));
            chk("trap_cause", 32'(trap_cause), 32'(ce.cause));
            chk("retire", 32'(retire), 32'(ce.ret));
            if (ce.chk_wd) chk("rf_wdata", rf_wdata, ce.wd);
        end
    end

    function automatic exp_t base();
        exp_t e;
        e.req    = 1'b0;
        e.we     = 1'b0;
        e.addr   = '0;
        e.wdata  = '0;
        e.ins    = instr_m;
        e.pcv    = pc_m;
        e.rfwe   = 1'b0;
        e.chk_wd = 1'b0;
        e.wd     = '0;
        e.trp    = 1'b0;
        e.cause  = cause_m;
        e.ret    = 1'b0;
        return e;
    endfunction

    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic spurious();
        mem_ack   = 1'($urandom);
        mem_err   = 1'($urandom);
        mem_rdata = $urandom;
    endtask

    task automatic access(input logic [31:0] addr, input bit we,
                          input logic [31:0] wdata, input int wait_n,
                          input bit err, input logic [31:0] rdata,
                          input int abort_n, output bit tmo,
                          output bit ab);
        exp_t e;
        tmo = 1'b0;
        ab  = 1'b0;
        for (int i = 0; i <= wait_n; i++) begin
            if (i == abort_n) begin
                ab = 1'b1;
                return;
            end
`ifdef CORE_SEQ_TIMEOUT_EN
            if (i == TMO) begin
                tmo = 1'b1;
                return;
            end
`endif
            e         = base();
            e.req     = 1'b1;
            e.addr    = addr;
            e.we      = we;
            e.wdata   = wdata;
            mem_ack   = (i == wait_n);
            mem_err   = (i == wait_n) ? err : 1'($urandom);
            mem_rdata = (i == wait_n) ? rdata : $urandom;
            step(e);
        end
    endtask

    task automatic trap_cycle(input logic [1:0] c);
        exp_t e;
        cause_m = c;
        pc_m    = RV;
        e       = base();
        e.trp   = 1'b1;
        spurious();
        step(e);
    endtask

    task automatic do_reset();
        exp_t e;
        reset_n  = 1'b0;
        pc_m     = RV;
        instr_m  = 32'h0000_0013;
        cause_m  = 2'd0;
        e        = base();
        e.chk_wd = 1'b1;
        spurious();
        step(e);
        spurious();
        step(e);
        reset_n   = 1'b1;
        mem_ack   = 1'b1;
        mem_err   = 1'b0;
        mem_rdata = $urandom;
        step(e);
    endtask

    task automatic run_instr(input int fw, input bit ferr,
                             input logic [31:0] iw, input bit ld,
                             input bit st, input bit br, input bit wb,
                             input bit ill, input bit tk,
                             input logic [31:0] alu,
                             input logic [31:0] rs2, input int mw,
                             input bit merr, input logic [31:0] mrd,
                             input int abort_n);
        exp_t e;
        bit   tmo;
        bit   ab;
        dec_load     = ld;
        dec_store    = st;
        dec_branch   = br;
        dec_wb       = wb;
        dec_illegal  = ill;
        branch_taken = tk;
        alu_result   = alu;
        rs2_data     = rs2;
        access(pc_m, 1'b0, 32'h0, fw, ferr, iw, -1, tmo, ab);
        if (tmo) begin
            trap_cycle(2'd3);
            return;
        end
        if (ferr) begin
            trap_cycle(2'd2);
            return;
        end
        instr_m = iw;
        e = base();
        spurious();
        step(e);
        if (ill) begin
            trap_cycle(2'd1);
            return;
        end
        if (ld || st) begin
            access(alu, st, rs2, mw, merr, mrd, abort_n, tmo, ab);
            if (ab) begin
                do_reset();
                return;
            end
            if (tmo) begin
                trap_cycle(2'd3);
                return;
            end
            if (merr) begin
                trap_cycle(2'd2);
                return;
            end
        end
        e        = base();
        e.rfwe   = wb && !st && !br;
        e.ret    = 1'b1;
        e.chk_wd = 1'b1;
        e.wd     = ld ? mrd : alu;
        spurious();
        step(e);
        pc_m = (br && tk) ? alu : pc_m + 32'd4;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit l, s, b, il;
        reset_n      = 1'b0;
        mem_ack      = 1'b0;
        mem_err      = 1'b0;
        mem_rdata    = '0;
        dec_load     = 1'b0;
        dec_store    = 1'b0;
        dec_branch   = 1'b0;
        dec_wb       = 1'b0;
        dec_illegal  = 1'b0;
        alu_result   = '0;
        branch_taken = 1'b0;
        rs2_data     = '0;
        pc_m         = RV;
        instr_m      = 32'h0000_0013;
        cause_m      = 2'd0;
        @(posedge clk);
        #1;
        do_reset();
        chk("lit_first_fetch_addr", mem_addr, 32'h0);

        run_instr(0, 0, 32'h0050_0093, 0, 0, 0, 1, 0, 0,
                  32'h5, 32'h0, 0, 0, 32'h0, -1);
        chk("lit_alu_wd", last_wd, 32'h5);
        chk("lit_alu_pc", pc, 32'h4);
        chk("lit_alu_instr", instr, 32'h0050_0093);

        run_instr(0, 0, 32'h1000_2083, 1, 0, 0, 1, 0, 0,
                  32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, -1);
        chk("lit_load_wd", last_wd, 32'hDEAD_BEEF);
        chk("lit_load_pc", pc, 32'h8);

        run_instr(1, 0, 32'h2020_2023, 0, 1, 0, 1, 0, 0,
                  32'h200, 32'h1234_5678, 2, 0, 32'h0, -1);
        chk("lit_store_wdata", last_st, 32'h1234_5678);
        chk("lit_store_pc", pc, 32'hC);

        run_instr(0, 0, 32'h0000_0063, 0, 0, 1, 1, 0, 1,
                  32'h40, 32'h0, 0, 0, 32'h0, -1);
        chk("lit_br_taken_pc", pc, 32'h40);
        run_instr(0, 0, 32'h0000_1063, 0, 0, 1, 0, 0, 0,
                  32'h80, 32'h0, 0, 0, 32'h0, -1);
        chk("lit_br_not_taken_pc", pc, 32'h44);

        run_instr(0, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 1, 0,
                  32'h7, 32'h0, 0, 0, 32'h0, -1);
        chk("lit_ill_cause", 32'(trap_cause), 32'h1);
        chk("lit_ill_pc", pc, RV);

        run_instr(2, 1, 32'h0, 0, 0, 0, 1, 0, 0,
                  32'h9, 32'h0, 0, 0, 32'h0, -1);
        chk("lit_ferr_cause", 32'(trap_cause), 32'h2);

        run_instr(0, 0, 32'h0000_0063, 0, 0, 1, 0, 0, 1,
                  32'hFFFF_FFFC, 32'h0, 0, 0, 32'h0, -1);
        run_instr(0, 0, 32'h0000_0013, 0, 0, 0, 1, 0, 0,
                  32'h1, 32'h0, 0, 0, 32'h0, -1);
        chk("lit_pc_wrap", pc, 32'h0);

        run_instr(0, 0, 32'h3000_2083, 1, 0, 0, 1, 0, 0,
                  32'h300, 32'h0, 50, 0, 32'h0, 3);
        chk("lit_abort_req", 32'(mem_req), 32'h1);
        chk("lit_abort_addr", mem_addr, RV);

        run_instr(100, 0, 32'h0000_0013, 0, 0, 0, 1, 0, 0,
                  32'h11, 32'h0, 0, 0, 32'h0, -1);
`ifdef CORE_SEQ_TIMEOUT_EN
        chk("lit_tmo_cause", 32'(trap_cause), 32'h3);
`else
        chk("lit_long_wait_pc", pc, 32'h4);
`endif

        for (int n = 0; n < 300; n++) begin
            k  = int'($urandom_range(0, 19));
            l  = (k >= 8 && k < 12);
            s  = (k >= 12 && k < 15);
            b  = (k >= 15 && k < 19);
            il = (k == 19);
            run_instr(int'($urandom_range(0, 3)),
                      ($urandom_range(0, 24) == 0), $urandom,
                      l, s, b, 1'($urandom), il, 1'($urandom),
                      $urandom, $urandom,
                      int'($urandom_range(0, 3)),
                      ($urandom_range(0, 24) == 0), $urandom, -1);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
